disp_sched: RTL

- Schedules which of four 16-bit debug sources (e.g. PC, ALU result, memory data, register readback) drives the board's 4-digit hex display multiplexer.
- Supports a manual mode (button steps through sources) and an auto mode (rotates after a fixed dwell time).
- Skips sources not currently valid, and supports freezing the displayed value.
- Sits between the CPU debug taps and the 7-segment driver's 16-bit value input.

---
 rtl/disp_sched.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/disp_sched.sv
// disp_sched: picks which of four 16-bit debug taps feeds the 4-digit hex
// display. Manual mode steps on a debounced button press. Auto mode rotates
// after DWELL_CYCLES. Invalid sources are skipped, and freeze holds the value.
//
// Ports:
//   clk, clr_n          clock, asynchronous active-low reset
//   src0..src3 [15:0]   debug taps
//   src_valid  [3:0]    bit i set -> srci may be shown
//   btn_next, btn_mode  raw push buttons (synchronized + debounced here)
//   freeze              hold disp_x while selection keeps updating
//   disp_x     [15:0]   registered value to the 7-segment driver
//   src_sel    [1:0]    selected source index
//   auto_mode           1 = auto rotation, 0 = manual stepping
//   disp_en             0 = nothing valid, blank the display

// Per-button path: 2-flop synchronizer, level debouncer, rising-edge pulse.
module disp_sched_deb #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic clr_n,
   input  logic btn,
   output logic pulse
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          lvl;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync  <= '0;
         cnt   <= '0;
         lvl   <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[0], btn};
         pulse <= 1'b0;
         if (sync[1] != lvl) begin
            // cnt == LAST means this is the DEBOUNCE_CYCLES-th differing cycle
            if (cnt == CNT_LAST) begin
               lvl   <= sync[1];
               cnt   <= '0;
               pulse <= sync[1];   // press only; release is silent
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;             // bounce back restarts the count
         end
      end
   end
endmodule

module disp_sched #(
   parameter int DWELL_CYCLES    = 50000000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic [15:0] src0,
   input  logic [15:0] src1,
   input  logic [15:0] src2,
   input  logic [15:0] src3,
   input  logic [3:0]  src_valid,
   input  logic        btn_next,
   input  logic        btn_mode,
   input  logic        freeze,
   output logic [15:0] disp_x,
   output logic [1:0]  src_sel,
   output logic        auto_mode,
   output logic        disp_en
);
   localparam int DW = $clog2(DWELL_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

   typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;

   state_t             state, state_nxt;
   logic [1:0]         btn_raw, btn_pulse;
   logic               p_next, p_mode;
   logic [DW-1:0]      dwell;
   logic [1:0]         nxt_sel, cand;
   logic [3:0][15:0]   srcs;
   logic               any_valid, cur_inv, expire;

   assign btn_raw = {btn_mode, btn_next};
   assign p_next  = btn_pulse[0];
   assign p_mode  = btn_pulse[1];

   generate
      for (genvar b = 0; b < 2; b++) begin : g_btn
         disp_sched_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .clr_n (clr_n),
            .btn   (btn_raw[b]),
            .pulse (btn_pulse[b])
         );
      end
   endgenerate

   assign srcs      = {src3, src2, src1, src0};
   assign any_valid = |src_valid;
   assign cur_inv   = any_valid && !src_valid[src_sel];
   assign expire    = (dwell == DWELL_LAST);

   // Walk offsets 3..1 so the nearest valid successor is written last and wins.
   always_comb begin
      nxt_sel = src_sel;
      cand    = src_sel;
      for (int k = 3; k >= 1; k--) begin
         cand = src_sel + 2'(k);
         if (src_valid[cand]) nxt_sel = cand;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) state <= MANUAL;
      else        state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      if (p_mode) state_nxt = (state == AUTO) ? MANUAL : AUTO;
   end

   // FSM: outputs
   always_comb begin
      auto_mode = (state == AUTO);
   end

   // Selection and dwell. Invalid current source outranks p_next and expiry,
   // so there is never more than one advance per cycle.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         src_sel <= '0;
         dwell   <= '0;
      end else if (!any_valid) begin
         dwell <= '0;
      end else if (cur_inv) begin
         src_sel <= nxt_sel;
         dwell   <= '0;
      end else if (state == MANUAL) begin
         dwell <= '0;
         if (p_next) src_sel <= nxt_sel;
      end else begin
         if (expire) begin
            src_sel <= nxt_sel;
            dwell   <= '0;
         end else begin
            dwell <= dwell + 1'b1;
         end
         if (p_mode) dwell <= '0;   // leaving AUTO; counter rests at 0
      end
   end

   // Output register: loads from the selection as it stood at cycle start,
   // so a src_sel change lands on disp_x one edge later.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         disp_en <= 1'b0;
         disp_x  <= '0;
      end else begin
         disp_en <= any_valid;
         if (!any_valid)              disp_x <= '0;   // blanking beats freeze
         else if (disp_en && !freeze) disp_x <= srcs[src_sel];
      end
   end
endmodule
